// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write arbiter: data word layout,
// one-hot arbiter states and watchdog sizing.
package lcd_pkg;

    localparam int unsigned DATA_W = 9;
    localparam int unsigned DC_BIT = 8;
    localparam int unsigned WDT_W  = 23;
    localparam int unsigned N_CLT  = 2;

    localparam logic [DATA_W-1:0] DATA_IDLE_DFLT = DATA_W'(0);
    localparam logic [WDT_W-1:0]  WDT_MAX_DFLT   = WDT_W'(5_000_000);

    typedef enum logic [4:0] {
        S_INIT = 5'b00001,
        S_IDLE = 5'b00010,
        S_GNT0 = 5'b00100,
        S_GNT1 = 5'b01000,
        S_GAP  = 5'b10000
    } state_t;

    // One word on the lcd_write bus: D/C flag on top, payload below.
    typedef struct packed {
        logic              dc;
        logic [DC_BIT-1:0] payload;
    } lcd_word_t;

    // Client that owns the writer in a given state; zero outside the grant states.
    function automatic logic [N_CLT-1:0] grant_of(input state_t s);
        logic [N_CLT-1:0] g;
        g = '0;
        case (s)
            S_GNT0:  g = N_CLT'(2'b01);
            S_GNT1:  g = N_CLT'(2'b10);
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/lcd_wdt.sv
// Write watchdog: counts cycles of en_write without a completing wr_done and
// raises a sticky error once the budget is spent.
module lcd_wdt
    import lcd_pkg::*;
#(
    parameter logic [WDT_W-1:0] WDT_MAX = WDT_MAX_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic kick,
    output logic expire_c,
    output logic err
);

    logic [WDT_W-1:0] cnt;

    // A wr_done arriving on the last allowed cycle still counts as progress.
    assign expire_c = en && !kick && (cnt == WDT_MAX - WDT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || kick || expire_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WDT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (expire_c) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/lcd_wr_arbiter.sv
// Shares the single lcd_write engine: lcd_init pass-through until init_done,
// then whole-burst round-robin grants between the text and picture clients.
module lcd_wr_arbiter
    import lcd_pkg::*;
#(
    parameter logic [WDT_W-1:0]  WDT_MAX   = WDT_MAX_DFLT,
    parameter logic [DATA_W-1:0] DATA_IDLE = DATA_IDLE_DFLT
) (
    input  logic        sys_clk_50MHz,
    input  logic        sys_rst_n,
    input  logic [8:0]  init_data,
    input  logic        init_en_write,
    input  logic        init_done,
    input  logic [1:0]  req,
    input  logic [8:0]  clt0_data,
    input  logic [8:0]  clt1_data,
    input  logic [1:0]  clt_last,
    input  logic        wr_done,
    output logic [8:0]  lcd_data,
    output logic        en_write,
    output logic [1:0]  grant,
    output logic [1:0]  clt_wr_done,
    output logic        init_wr_done,
    output logic        wdt_err
);

    state_t           state;
    state_t           state_nxt;
    logic             rr_ptr;
    logic             rr_ptr_nxt;
    logic             wdt_expire;
    lcd_word_t        data_nxt;
    logic             en_nxt;
    logic [N_CLT-1:0] grant_nxt;

    lcd_wdt #(
        .WDT_MAX (WDT_MAX)
    ) u_wdt (
        .clk      (sys_clk_50MHz),
        .rst_n    (sys_rst_n),
        .en       (en_write),
        .kick     (wr_done),
        .expire_c (wdt_expire),
        .err      (wdt_err)
    );

    // State register.
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and round-robin pointer; any exit from a grant hands priority to the other client.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        case (state)
            S_INIT: begin
                if (init_done) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                case (req)
                    2'b01:   state_nxt = S_GNT0;
                    2'b10:   state_nxt = S_GNT1;
                    2'b11:   state_nxt = rr_ptr ? S_GNT1 : S_GNT0;
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_GNT0: begin
                if (wdt_expire || !req[0] || (wr_done && clt_last[0])) begin
                    state_nxt  = S_GAP;
                    rr_ptr_nxt = 1'b1;
                end
            end
            S_GNT1: begin
                if (wdt_expire || !req[1] || (wr_done && clt_last[1])) begin
                    state_nxt  = S_GAP;
                    rr_ptr_nxt = 1'b0;
                end
            end
            S_GAP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Output decode: registered values follow the next state, wr_done routing follows the current one.
    always_comb begin
        data_nxt     = lcd_word_t'(DATA_IDLE);
        en_nxt       = 1'b0;
        grant_nxt    = grant_of(state_nxt);
        clt_wr_done  = grant_of(state) & {N_CLT{wr_done}};
        init_wr_done = (state == S_INIT) && wr_done;
        case (state_nxt)
            S_INIT: begin
                data_nxt = lcd_word_t'(init_data);
                en_nxt   = init_en_write;
            end
            S_GNT0: begin
                data_nxt = lcd_word_t'(clt0_data);
                en_nxt   = 1'b1;
            end
            S_GNT1: begin
                data_nxt = lcd_word_t'(clt1_data);
                en_nxt   = 1'b1;
            end
            default: begin
                data_nxt = lcd_word_t'(DATA_IDLE);
                en_nxt   = 1'b0;
            end
        endcase
    end

    // Registered bus towards lcd_write; reset drops en_write at once.
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lcd_data <= DATA_IDLE;
            en_write <= 1'b0;
            grant    <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            lcd_data <= DATA_W'(data_nxt);
            en_write <= en_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_wr_arbiter.sv
// Directed bench for lcd_wr_arbiter; client words go into a scoreboard queue and
// are compared against lcd_data each time the lcd_write model accepts a word.
module tb_lcd_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] init_data;
    logic       init_en_write;
    logic       init_done;
    logic [1:0] req;
    logic [8:0] clt0_data;
    logic [8:0] clt1_data;
    logic [1:0] clt_last;
    logic       wr_done;
    logic [8:0] lcd_data;
    logic       en_write;
    logic [1:0] grant;
    logic [1:0] clt_wr_done;
    logic       init_wr_done;
    logic       wdt_err;

    int         errors = 0;
    int         checks = 0;
    int         pulse_cnt0 = 0;
    int         pulse_cnt1 = 0;
    logic [8:0] exp_q [$];
    logic [8:0] bw [2][8];

    lcd_wr_arbiter #(
        .WDT_MAX   (23'd16),
        .DATA_IDLE (9'h000)
    ) dut (
        .sys_clk_50MHz (clk),
        .sys_rst_n     (rst_n),
        .init_data     (init_data),
        .init_en_write (init_en_write),
        .init_done     (init_done),
        .req           (req),
        .clt0_data     (clt0_data),
        .clt1_data     (clt1_data),
        .clt_last      (clt_last),
        .wr_done       (wr_done),
        .lcd_data      (lcd_data),
        .en_write      (en_write),
        .grant         (grant),
        .clt_wr_done   (clt_wr_done),
        .init_wr_done  (init_wr_done),
        .wdt_err       (wdt_err)
    );

    always #5 clk = ~clk;

    // Independent count of routed wr_done pulses per client.
    always @(negedge clk) begin
        if (clt_wr_done[0] === 1'b1) pulse_cnt0 <= pulse_cnt0 + 1;
        if (clt_wr_done[1] === 1'b1) pulse_cnt1 <= pulse_cnt1 + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int c);
        return (c == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic set_clt(input int c, input logic [8:0] w);
        if (c == 0) clt0_data = w;
        else        clt1_data = w;
    endtask

    task automatic start_req(input int c, input int nw);
        set_clt(c, bw[c][0]);
        clt_last[c] = (nw == 1);
        req[c]      = 1'b1;
    endtask

    // Runs a granted burst of nw words; the client drops req after n_acc accepted words if n_acc < nw.
    task automatic burst(input int c, input int nw, input int n_acc);
        exp_q.push_back(bw[c][0]);
        for (int i = 0; i < nw; i++) begin
            if (i == n_acc) begin
                req[c]      = 1'b0;
                clt_last[c] = 1'b0;
                cyc();
                chk("abort_en", 16'(en_write), 16'(0));
                chk("abort_grant", 16'(grant), 16'(0));
                void'(exp_q.pop_front());
                return;
            end
            chk("burst_grant", 16'(grant), 16'(onehot(c)));
            chk("burst_en", 16'(en_write), 16'(1));
            wr_done = 1'b1;
            #1;
            chk("clt_wr_done", 16'(clt_wr_done), 16'(onehot(c)));
            chk("lcd_data", 16'(lcd_data), 16'(exp_q.pop_front()));
            cyc();
            wr_done = 1'b0;
            if (i < nw - 1) begin
                set_clt(c, bw[c][i+1]);
                clt_last[c] = (i + 1 == nw - 1);
                exp_q.push_back(bw[c][i+1]);
                cyc();
            end else begin
                req[c]      = 1'b0;
                clt_last[c] = 1'b0;
                #1;
                chk("gap_en", 16'(en_write), 16'(0));
                chk("gap_grant", 16'(grant), 16'(0));
            end
        end
    endtask

    initial begin
        int p0;
        int p1;
        bw[0][0] = 9'h02a; bw[0][1] = 9'h100; bw[0][2] = 9'h1ef;
        bw[1][0] = 9'h0de; bw[1][1] = 9'h1ad;
        rst_n = 1'b0; init_data = '0; init_en_write = 1'b0; init_done = 1'b0;
        req = '0; clt0_data = '0; clt1_data = '0; clt_last = '0; wr_done = 1'b0;

        // reset
        repeat (5) cyc();
        chk("rst_grant", 16'(grant), 16'(0));
        chk("rst_en", 16'(en_write), 16'(0));
        chk("rst_data", 16'(lcd_data), 16'h000);
        chk("rst_wdt", 16'(wdt_err), 16'(0));
        chk("rst_cwd", 16'(clt_wr_done), 16'(0));
        rst_n = 1'b1;

        // init pass-through, client requests ignored
        init_data = 9'h011; init_en_write = 1'b1; req = 2'b11;
        clt0_data = 9'h1ff; clt1_data = 9'h0ff;
        cyc();
        chk("init_data", 16'(lcd_data), 16'h011);
        chk("init_en", 16'(en_write), 16'(1));
        chk("init_grant", 16'(grant), 16'(0));
        wr_done = 1'b1;
        #1;
        chk("init_wr_done", 16'(init_wr_done), 16'(1));
        chk("init_cwd", 16'(clt_wr_done), 16'(0));
        cyc();
        wr_done = 1'b0; init_en_write = 1'b0;
        #1;
        chk("init_wr_done_lo", 16'(init_wr_done), 16'(0));
        cyc();
        chk("init_en_lo", 16'(en_write), 16'(0));
        chk("init_grant2", 16'(grant), 16'(0));
        req = 2'b00; init_done = 1'b1;
        cyc();
        chk("idle_data", 16'(lcd_data), 16'h000);
        chk("idle_grant", 16'(grant), 16'(0));

        // single client 0 burst
        p0 = pulse_cnt0;
        start_req(0, 3);
        cyc();
        burst(0, 3, 3);
        cyc();
        chk("t3_idle_grant", 16'(grant), 16'(0));
        chk("t3_pulses", 16'(pulse_cnt0 - p0), 16'(3));

        // client 1 alone; rr pointer returns to client 0
        start_req(1, 2);
        cyc();
        burst(1, 2, 2);
        cyc();

        // contention: client 0 first, then client 1
        bw[0][0] = 9'h101; bw[0][1] = 9'h0f0; bw[0][2] = 9'h1a5; bw[0][3] = 9'h05a;
        bw[1][0] = 9'h1c3; bw[1][1] = 9'h03c; bw[1][2] = 9'h199;
        start_req(0, 4);
        start_req(1, 3);
        p1 = pulse_cnt1;
        cyc();
        burst(0, 4, 4);
        chk("t4_c1_quiet", 16'(pulse_cnt1 - p1), 16'(0));
        cyc();
        chk("t4_idle_grant", 16'(grant), 16'(0));
        cyc();
        burst(1, 3, 3);
        cyc();
        bw[0][0] = 9'h111; bw[1][0] = 9'h022;
        start_req(0, 1);
        start_req(1, 1);
        cyc();
        chk("t4_rr_second", 16'(grant), 16'(2'b01));
        burst(0, 1, 1);
        cyc();
        cyc();
        burst(1, 1, 1);
        cyc();

        // abort mid-burst
        bw[1][0] = 9'h1aa; bw[1][1] = 9'h055; bw[1][2] = 9'h0cc; bw[1][3] = 9'h133;
        start_req(1, 4);
        cyc();
        burst(1, 4, 1);
        cyc();
        chk("abort_idle", 16'(grant), 16'(0));

        // watchdog: client 0 granted, wr_done withheld
        bw[0][0] = 9'h0a0; bw[0][1] = 9'h0b0;
        start_req(0, 2);
        cyc();
        repeat (15) cyc();
        chk("wdt_pre_err", 16'(wdt_err), 16'(0));
        chk("wdt_pre_en", 16'(en_write), 16'(1));
        chk("wdt_pre_grant", 16'(grant), 16'(2'b01));
        cyc();
        chk("wdt_err", 16'(wdt_err), 16'(1));
        chk("wdt_grant", 16'(grant), 16'(0));
        chk("wdt_en", 16'(en_write), 16'(0));
        req = 2'b00; clt_last = 2'b00;
        repeat (3) cyc();
        chk("wdt_sticky", 16'(wdt_err), 16'(1));

        // reset during a client 1 stream
        bw[1][0] = 9'h1e1; bw[1][1] = 9'h1e2; bw[1][2] = 9'h1e3;
        start_req(1, 3);
        cyc();
        chk("t6_grant", 16'(grant), 16'(2'b10));
        rst_n = 1'b0; init_done = 1'b0;
        #1;
        chk("t6_rst_en", 16'(en_write), 16'(0));
        chk("t6_rst_grant", 16'(grant), 16'(0));
        chk("t6_rst_wdt", 16'(wdt_err), 16'(0));
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        chk("t6_init_grant", 16'(grant), 16'(0));
        chk("t6_init_en", 16'(en_write), 16'(0));
        init_data = 9'h155; init_en_write = 1'b1;
        cyc();
        chk("t6_init_data", 16'(lcd_data), 16'h155);
        chk("t6_init_grant2", 16'(grant), 16'(0));
        init_en_write = 1'b0; req = 2'b00; clt_last = 2'b00; init_done = 1'b1;
        cyc();
        bw[0][0] = 9'h0c0; bw[1][0] = 9'h0c1;
        start_req(0, 1);
        start_req(1, 1);
        cyc();
        chk("t6_rr_reset", 16'(grant), 16'(2'b01));
        burst(0, 1, 1);
        cyc();
        cyc();
        burst(1, 1, 1);
        cyc();
        chk("sb_empty", 16'(exp_q.size()), 16'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
